iterative_alu: RTL

- Parametrised, multi-cycle successor to the datapath's single-cycle ALU.
- Keeps the existing ALUOperation encodings for AND/OR/NOR/ADD/SUB/SLL and adds SRL, unsigned MUL and unsigned DIV. MUL and DIV are computed iteratively, one bit per clock.
- Sits in the execute stage of the multicycle MIPS core. The control FSM issues operations with a start/done handshake, and HI/LO-style results are presented on `result` and `hi`.

---
 rtl/iterative_alu.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/iterative_alu.sv
// Multi-cycle execute-stage ALU: single-cycle logic/add/shift ops plus
// iterative unsigned MUL (shift-add) and DIV (restoring), one bit per clock.
module iterative_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUOperation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             Zero,
  output logic             div_by_zero
);

  localparam int unsigned CW = SHW + 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [3:0] OP_DIV = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b1110;
  localparam logic [3:0] OP_SRL = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [3:0]       op_q, op_n;
  logic [WIDTH-1:0] opnd_q, opnd_n;   // multiplicand for MUL, divisor for DIV
  logic [WIDTH-1:0] acc_q, acc_n;     // partial product high / partial remainder
  logic [WIDTH-1:0] lo_q, lo_n;       // multiplier / dividend-quotient shift register
  logic [CW-1:0]    cnt_q, cnt_n;

  logic [WIDTH-1:0] result_n, hi_n;
  logic             zero_n, dbz_n, done_n, busy_n;

  logic [WIDTH-1:0] quick_res, quick_hi;
  logic             quick_dbz;
  logic             iter_op;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] iter_acc, iter_lo;

  // Single-cycle results, computed straight from the issuing inputs
  always_comb begin
    quick_res = '0;
    quick_hi  = '0;
    quick_dbz = 1'b0;
    unique case (ALUOperation)
      OP_AND: quick_res = A & B;
      OP_OR:  quick_res = A | B;
      OP_NOR: quick_res = ~(A | B);
      OP_ADD: quick_res = A + B;
      OP_SUB: quick_res = A - B;
      OP_SLL: quick_res = A << shamt;
      OP_SRL: quick_res = A >> shamt;
      OP_DIV: begin
        quick_res = '1;
        quick_hi  = A;
        quick_dbz = 1'b1;
      end
      default: quick_res = '0;
    endcase
  end

  assign iter_op = (ALUOperation == OP_MUL) ||
                   ((ALUOperation == OP_DIV) && (B != '0));

  // One MUL or DIV step on the working registers
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    if (op_q == OP_DIV) begin
      iter_acc = div_ge ? div_diff : div_shift[WIDTH-1:0];
      iter_lo  = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      iter_acc = mul_sum[WIDTH:1];
      iter_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_n  = state;
    op_n     = op_q;
    opnd_n   = opnd_q;
    acc_n    = acc_q;
    lo_n     = lo_q;
    cnt_n    = cnt_q;
    result_n = result;
    hi_n     = hi;
    zero_n   = Zero;
    dbz_n    = div_by_zero;
    done_n   = 1'b0;
    busy_n   = 1'b0;

    unique case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (start) begin
          op_n = ALUOperation;
          if (iter_op) begin
            opnd_n  = (ALUOperation == OP_MUL) ? A : B;
            lo_n    = (ALUOperation == OP_MUL) ? B : A;
            acc_n   = '0;
            cnt_n   = CW'(WIDTH);
            state_n = RUN;
            busy_n  = 1'b1;
          end else begin
            state_n  = DONE;
            done_n   = 1'b1;
            result_n = quick_res;
            hi_n     = quick_hi;
            zero_n   = (quick_res == '0);
            dbz_n    = quick_dbz;
          end
        end
      end
      RUN: begin
        acc_n = iter_acc;
        lo_n  = iter_lo;
        cnt_n = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_n  = DONE;
          done_n   = 1'b1;
          result_n = iter_lo;
          hi_n     = iter_acc;
          zero_n   = (iter_lo == '0);
          dbz_n    = 1'b0;
        end else begin
          busy_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      op_q        <= '0;
      opnd_q      <= '0;
      acc_q       <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      result      <= '0;
      hi          <= '0;
      Zero        <= 1'b1;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      op_q        <= op_n;
      opnd_q      <= opnd_n;
      acc_q       <= acc_n;
      lo_q        <= lo_n;
      cnt_q       <= cnt_n;
      result      <= result_n;
      hi          <= hi_n;
      Zero        <= zero_n;
      div_by_zero <= dbz_n;
      done        <= done_n;
      busy        <= busy_n;
    end
  end

endmodule
